// File: rtl/ltc5548_sys_pio_in_if.sv
// Avalon-MM register-slave bus for the LTC5548 input PIO: zero-wait-state
// access with combinational readdata plus the level interrupt to the CPU.
interface ltc5548_sys_pio_in_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/ltc5548_sys_pio_in.sv
// Input PIO: two-flop synchronizer, per-bit debounce, edge capture with W1C
// clear and a maskable level interrupt, behind an Avalon-MM register slave.
module ltc5548_sys_pio_in #(
    parameter int          WIDTH      = 4,
    parameter logic [15:0] DB_DEFAULT = 16'd1000,
    parameter int          EDGE_TYPE  = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    ltc5548_sys_pio_in_if.slave  bus,
    input  logic [WIDTH-1:0]     in_port
);

    localparam logic [2:0] ADDR_DATA  = 3'd0;
    localparam logic [2:0] ADDR_DBPER = 3'd1;
    localparam logic [2:0] ADDR_MASK  = 3'd2;
    localparam logic [2:0] ADDR_EDGE  = 3'd3;

    logic [WIDTH-1:0] sync1_reg;
    logic [WIDTH-1:0] sync2_reg;
    logic [WIDTH-1:0] stable_reg;
    logic [WIDTH-1:0] stable_next;
    logic [WIDTH-1:0] edge_event;
    logic [WIDTH-1:0] mask_reg;
    logic [WIDTH-1:0] mask_next;
    logic [WIDTH-1:0] edge_reg;
    logic [WIDTH-1:0] edge_next;
    logic [WIDTH-1:0] w1c;
    logic [15:0]      dbper_reg;
    logic [15:0]      dbper_next;
    logic [15:0]      threshold;
    logic             wr_strobe;
    logic             unused_ok;

    assign wr_strobe = bus.chipselect && !bus.write_n;
    assign unused_ok = &{1'b0, bus.writedata};

    // A period of 0 qualifies in one cycle, same as a period of 1.
    assign threshold = (dbper_reg == 16'd0) ? 16'd0 : dbper_reg - 16'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= in_port;
            sync2_reg <= sync1_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic [15:0] cnt_reg;
            logic [15:0] cnt_next;
            logic        load;

            // The >= compare lets a lowered period release a counter that is
            // already past the new threshold on the very next cycle.
            always_comb begin
                cnt_next = cnt_reg;
                load     = 1'b0;
                if (sync2_reg[gi] == stable_reg[gi]) begin
                    cnt_next = '0;
                end else if (cnt_reg >= threshold) begin
                    cnt_next = '0;
                    load     = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_next;
                end
            end

            assign stable_next[gi] = load ? sync2_reg[gi] : stable_reg[gi];

            if (EDGE_TYPE == 0) begin : g_rise
                assign edge_event[gi] = load & sync2_reg[gi];
            end else if (EDGE_TYPE == 1) begin : g_fall
                assign edge_event[gi] = load & ~sync2_reg[gi];
            end else begin : g_any
                assign edge_event[gi] = load;
            end
        end
    endgenerate

    always_comb begin
        dbper_next = dbper_reg;
        mask_next  = mask_reg;
        w1c        = '0;
        if (wr_strobe) begin
            case (bus.address)
                ADDR_DBPER: dbper_next = bus.writedata[15:0];
                ADDR_MASK:  mask_next  = bus.writedata[WIDTH-1:0];
                ADDR_EDGE:  w1c        = bus.writedata[WIDTH-1:0];
                default: ;
            endcase
        end
        // A new event on a bit being cleared in the same cycle keeps it set.
        edge_next = edge_event | (edge_reg & ~w1c);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_reg <= '0;
            mask_reg   <= '0;
            edge_reg   <= '0;
            dbper_reg  <= DB_DEFAULT;
        end else begin
            stable_reg <= stable_next;
            mask_reg   <= mask_next;
            edge_reg   <= edge_next;
            dbper_reg  <= dbper_next;
        end
    end

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            ADDR_DATA:  bus.readdata = 32'(stable_reg);
            ADDR_DBPER: bus.readdata = 32'(dbper_reg);
            ADDR_MASK:  bus.readdata = 32'(mask_reg);
            ADDR_EDGE:  bus.readdata = 32'(edge_reg);
            default:    bus.readdata = '0;
        endcase
    end

    assign bus.irq = |(edge_reg & mask_reg);

endmodule

// File: tb/tb_ltc5548_sys_pio_in.sv
// Directed bench for the input PIO: register-map table followed by
// hand-timed sequences for debounce, edge capture, W1C, masking and reset.
module tb_ltc5548_sys_pio_in;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] in_port = 4'h0;
    int         total = 0;
    int         bad = 0;

    ltc5548_sys_pio_in_if bus_if ();

    ltc5548_sys_pio_in #(
        .WIDTH      (4),
        .DB_DEFAULT (16'd1000),
        .EDGE_TYPE  (0)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if),
        .in_port (in_port)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        bus_if.address    = a;
        bus_if.writedata  = d;
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b0;
        @(posedge clk);
        #1;
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        bus_if.address    = a;
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b1;
        #1;
        d = bus_if.readdata;
        bus_if.chipselect = 1'b0;
    endtask

    task automatic check_reg(input string name, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(name, d, exp);
    endtask

    task automatic drive_in(input logic [3:0] v);
        @(negedge clk);
        in_port = v;
    endtask

    initial begin
        logic [31:0] rd;

        vecs[0]  = '{3'd0, 1'b0, 32'h0,        32'h0,    1'b0};
        vecs[1]  = '{3'd1, 1'b0, 32'h0,        32'd1000, 1'b0};
        vecs[2]  = '{3'd2, 1'b0, 32'h0,        32'h0,    1'b0};
        vecs[3]  = '{3'd3, 1'b0, 32'h0,        32'h0,    1'b0};
        vecs[4]  = '{3'd4, 1'b0, 32'h0,        32'h0,    1'b0};
        vecs[5]  = '{3'd1, 1'b1, 32'h000ABCD5, 32'hBCD5, 1'b0};
        vecs[6]  = '{3'd2, 1'b1, 32'hFFFFFFF6, 32'h6,    1'b0};
        vecs[7]  = '{3'd0, 1'b1, 32'hF,        32'h0,    1'b0};
        vecs[8]  = '{3'd3, 1'b1, 32'hF,        32'h0,    1'b0};
        vecs[9]  = '{3'd6, 1'b1, 32'h1234,     32'h0,    1'b0};
        vecs[10] = '{3'd7, 1'b1, 32'hFFFF,     32'h0,    1'b0};
        vecs[11] = '{3'd1, 1'b1, 32'h0,        32'h0,    1'b0};
        vecs[12] = '{3'd2, 1'b1, 32'h0,        32'h0,    1'b0};

        bus_if.address    = 3'd0;
        bus_if.writedata  = 32'h0;
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("reset_irq", 32'(bus_if.irq), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Register map table
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].wdata);
            bus_read(vecs[i].addr, rd);
            check($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
            check($sformatf("vec%0d_irq", i), 32'(bus_if.irq), 32'(vecs[i].exp_irq));
        end

        // Basic rising capture, N=3: stable loads at edge k+4
        bus_write(3'd1, 32'd3);
        bus_write(3'd2, 32'h1);
        drive_in(4'b0001);
        repeat (4) @(posedge clk);
        #1;
        check_reg("rise_data_early", 3'd0, 32'h0);
        check_reg("rise_edge_early", 3'd3, 32'h0);
        check("rise_irq_early", 32'(bus_if.irq), 32'h0);
        @(posedge clk);
        #1;
        check_reg("rise_data", 3'd0, 32'h1);
        check_reg("rise_edge", 3'd3, 32'h1);
        check("rise_irq", 32'(bus_if.irq), 32'h1);
        bus_write(3'd3, 32'h1);
        check("rise_w1c_irq", 32'(bus_if.irq), 32'h0);
        drive_in(4'b0000);
        repeat (10) @(posedge clk);
        #1;
        check_reg("fall_data", 3'd0, 32'h0);
        check_reg("fall_no_edge", 3'd3, 32'h0);

        // Glitch rejection, N=8
        bus_write(3'd1, 32'd8);
        bus_write(3'd2, 32'h2);
        drive_in(4'b0010);
        repeat (5) @(posedge clk);
        drive_in(4'b0000);
        repeat (20) @(posedge clk);
        #1;
        check_reg("glitch5_data", 3'd0, 32'h0);
        check_reg("glitch5_edge", 3'd3, 32'h0);
        check("glitch5_irq", 32'(bus_if.irq), 32'h0);
        drive_in(4'b0010);
        repeat (9) @(posedge clk);
        drive_in(4'b0000);
        repeat (20) @(posedge clk);
        #1;
        check_reg("pulse9_edge", 3'd3, 32'h2);
        check("pulse9_irq", 32'(bus_if.irq), 32'h1);
        bus_write(3'd3, 32'h2);

        // W1C colliding with a new event on bit0
        bus_write(3'd1, 32'd1);
        bus_write(3'd2, 32'h1);
        drive_in(4'b0011);
        repeat (5) @(posedge clk);
        #1;
        check_reg("coll_pre_edge", 3'd3, 32'h3);
        drive_in(4'b0010);
        repeat (5) @(posedge clk);
        drive_in(4'b0011);
        @(posedge clk);
        @(posedge clk);
        bus_write(3'd3, 32'h3);
        check_reg("coll_edge", 3'd3, 32'h1);
        check("coll_irq", 32'(bus_if.irq), 32'h1);

        // Mask gating
        bus_write(3'd3, 32'hF);
        bus_write(3'd2, 32'h0);
        drive_in(4'b0111);
        repeat (5) @(posedge clk);
        #1;
        check_reg("mask_edge", 3'd3, 32'h4);
        check("mask0_irq", 32'(bus_if.irq), 32'h0);
        bus_write(3'd2, 32'h4);
        check("mask4_irq", 32'(bus_if.irq), 32'h1);
        bus_write(3'd3, 32'h4);
        check("mask_w1c_irq", 32'(bus_if.irq), 32'h0);

        // DBPER lowered mid-count releases the counter next cycle
        bus_write(3'd1, 32'd100);
        drive_in(4'b0011);
        repeat (50) @(posedge clk);
        #1;
        check_reg("dbper_data_mid", 3'd0, 32'h7);
        bus_write(3'd1, 32'd10);
        check_reg("dbper_data_wr", 3'd0, 32'h7);
        @(posedge clk);
        #1;
        check_reg("dbper_data_after", 3'd0, 32'h3);
        check_reg("dbper_readback", 3'd1, 32'd10);
        check_reg("unmapped5", 3'd5, 32'h0);
        check_reg("dbper_no_edge", 3'd3, 32'h0);

        // Async reset mid-count with all edges pending
        bus_write(3'd1, 32'd1);
        drive_in(4'b0000);
        repeat (5) @(posedge clk);
        bus_write(3'd3, 32'hF);
        drive_in(4'b1111);
        repeat (5) @(posedge clk);
        bus_write(3'd2, 32'hF);
        check_reg("rst_pre_edge", 3'd3, 32'hF);
        check("rst_pre_irq", 32'(bus_if.irq), 32'h1);
        bus_write(3'd1, 32'd100);
        drive_in(4'b0000);
        repeat (20) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("rst_irq", 32'(bus_if.irq), 32'h0);
        check_reg("rst_data", 3'd0, 32'h0);
        check_reg("rst_edge", 3'd3, 32'h0);
        check_reg("rst_mask", 3'd2, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_reg("rst_dbper", 3'd1, 32'd1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
